// File: rtl/sti_dac_banked.sv
// sti_dac_banked -- serial transmit interface with banked byte packer.
//
// Builds an 8/16/24/32-bit frame from pi_data, shifts it out MSB- or
// LSB-first on so_data/so_valid, and packs every transmitted byte into
// BANKS odd/even memory pairs. On pi_end the rest of the memory is
// zero-padded and oem_finish is raised (sticky until reset).
//
// Optional build macro: CHECKER_EN -- odd/even parity flips every
// ROW_BYTES bytes (checkerboard layout). Undefined: parity = k[0].
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   load, pi_*          frame request and format controls, sampled on accept
//   pi_end              end of data, sampled in IDLE only (load wins)
//   ready               high in IDLE
//   so_data, so_valid   serial stream
//   oem_dataout/addr    byte and entry address for the memory write
//   odd_wr, even_wr     one-hot write strobes per bank pair
//   oem_finish          all CAP entries written
module sti_dac_banked #(
  parameter int PI_W      = 16,
  parameter int BANKS     = 4,
  parameter int DEPTH     = 32,
  parameter int ROW_BYTES = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [PI_W-1:0]   pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              ready,
  output logic              so_data,
  output logic              so_valid,
  output logic [7:0]        oem_dataout,
  output logic [ADDR_W-1:0] oem_addr,
  output logic [BANKS-1:0]  odd_wr,
  output logic [BANKS-1:0]  even_wr,
  output logic              oem_finish
);

  localparam int CAP = BANKS * 2 * DEPTH;
  localparam int KW  = $clog2(CAP) + 1;
  localparam int RB  = $clog2(ROW_BYTES);
`ifdef CHECKER_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, PAD, DONE} state_t;

  state_t          state, state_nx;
  logic [31:0]     sreg;      // outgoing bit is always sreg[31]
  logic [4:0]      cnt;       // bit index within the frame
  logic [4:0]      len_m1;    // L-1 of the latched frame
  logic [6:0]      acc;       // first seven bits of the current byte
  logic [KW-1:0]   k;         // byte counter, saturates at CAP
  logic            phase;     // PAD: 0 = write slot, 1 = idle slot

  // frame formatting
  logic [5:0]      len;
  logic [31:0]     ext, frame, sreg_ld;

  always_comb begin
    len   = {1'b0, pi_length, 3'b000} + 6'd8;
    ext   = 32'(pi_data);
    frame = ext;
    if (len < 6'(PI_W))
      frame = pi_low ? (ext >> (6'(PI_W) - len)) : (ext & ((32'd1 << len) - 32'd1));
    else if (len > 6'(PI_W))
      frame = pi_fill ? (ext << (len - 6'(PI_W))) : ext;
    // Left-align for MSB-first; a full 32-bit reversal puts F[0] on top
    // for LSB-first, so both orders shift out of bit 31.
    sreg_ld = frame << (6'd32 - len);
    if (!pi_msb)
      for (int i = 0; i < 32; i++) sreg_ld[i] = frame[31-i];
  end

  // FSM
  logic at_cap;
  assign at_cap = (k == KW'(CAP));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load) state_nx = SHIFT;
             else if (pi_end) state_nx = PAD;
      SHIFT: if (cnt == len_m1) state_nx = IDLE;
      PAD:   if (at_cap) state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // write decode
  logic            byte_end, wr, par;
  logic [7:0]      wr_byte;
  logic [KW-1:0]   grp;
  logic [BANKS-1:0] sel;

  always_comb begin
    byte_end = (state == SHIFT) && (cnt[2:0] == 3'b111);
    wr       = !at_cap && (byte_end || (state == PAD && !phase));
    wr_byte  = byte_end ? {acc, sreg[31]} : 8'h00;
    par      = k[0] ^ (CHK & k[RB]);
    grp      = k >> (ADDR_W + 1);
    sel      = BANKS'(1) << grp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg        <= '0;
      cnt         <= '0;
      len_m1      <= '0;
      acc         <= '0;
      k           <= '0;
      phase       <= 1'b0;
      oem_dataout <= '0;
      oem_addr    <= '0;
      odd_wr      <= '0;
      even_wr     <= '0;
    end else begin
      odd_wr  <= '0;
      even_wr <= '0;
      phase   <= (state == PAD) ? ~phase : 1'b0;
      if (state == IDLE && load) begin
        sreg   <= sreg_ld;
        cnt    <= '0;
        len_m1 <= {pi_length, 3'b111};
      end else if (state == SHIFT) begin
        sreg <= {sreg[30:0], 1'b0};
        cnt  <= cnt + 5'd1;
        acc  <= {acc[5:0], sreg[31]};
      end
      if (wr) begin
        oem_dataout <= wr_byte;
        oem_addr    <= k[ADDR_W:1];
        odd_wr      <= par ? '0 : sel;
        even_wr     <= par ? sel : '0;
        k           <= k + KW'(1);
      end
    end
  end

  // ready is gated so every output reads 0 while reset is held
  assign ready      = (state == IDLE) && !reset;
  assign so_valid   = (state == SHIFT);
  assign so_data    = so_valid & sreg[31];
  assign oem_finish = (state == DONE);

endmodule

// File: tb/tb_sti_dac_banked.sv
module tb_sti_dac_banked;

  localparam int CAP = 256;
`ifdef CHECKER_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 0, reset = 0, load = 0;
  logic [15:0] pi_data = 0;
  logic [1:0]  pi_length = 0;
  logic        pi_fill = 0, pi_msb = 0, pi_low = 0, pi_end = 0;
  logic        ready, so_data, so_valid, oem_finish;
  logic [7:0]  oem_dataout;
  logic [4:0]  oem_addr;
  logic [3:0]  odd_wr, even_wr;

  sti_dac_banked dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .ready(ready), .so_data(so_data),
    .so_valid(so_valid), .oem_dataout(oem_dataout), .oem_addr(oem_addr),
    .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  len;
    logic        fill, msb, low;
    logic [15:0] data;
    logic [31:0] exp;   // first-sent bit at [31]
  } vec_t;

  vec_t tv[10];
  int   checks = 0, errs = 0;
  int   exp_k = 0;
  logic       bits[$];
  logic [7:0] wrs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // serial capture and write-mapping scoreboard
  logic       mp;
  logic [3:0] msel;
  always @(negedge clk) begin
    if (reset) exp_k = 0;
    else begin
      if (so_valid) bits.push_back(so_data);
      if (odd_wr != 0 || even_wr != 0) begin
        mp   = exp_k[0] ^ (CHK & exp_k[3]);
        msel = 4'(1 << (exp_k / 64));
        chk("wr_addr", 32'(oem_addr), 32'((exp_k / 2) % 32));
        chk("odd_wr", 32'(odd_wr), 32'(mp ? 4'b0 : msel));
        chk("even_wr", 32'(even_wr), 32'(mp ? msel : 4'b0));
        wrs.push_back(oem_dataout);
        exp_k++;
      end
    end
  end

  task automatic do_reset(input string nm);
    #2 reset = 1;
    #1 chk({nm, "_outs_zero"}, 32'({so_data, so_valid, ready, oem_finish, odd_wr,
                                    even_wr, oem_addr, oem_dataout}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    chk({nm, "_ready"}, 32'(ready), 32'h1);
  endtask

  task automatic send(input vec_t v, input int nw, input string nm);
    int L, t;
    logic [31:0] got;
    L = 8 * (int'(v.len) + 1);
    t = 0;
    while (!ready && t < 100) begin @(posedge clk); #1; t++; end
    bits.delete(); wrs.delete();
    pi_length = v.len; pi_fill = v.fill; pi_msb = v.msb; pi_low = v.low; pi_data = v.data;
    load = 1;
    @(posedge clk); #1;
    load = 0;
    // later pi_* changes must not affect the latched frame
    pi_data = ~v.data; pi_msb = ~v.msb; pi_low = ~v.low; pi_fill = ~v.fill; pi_length = ~v.len;
    chk({nm, "_ready_low"}, 32'(ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 load = 1;     // must be ignored mid-frame
    @(posedge clk); #1;
    load = 0;
    t = 0;
    while (!ready && t < 40) begin @(posedge clk); #1; t++; end
    chk({nm, "_frame_cycles"}, 32'(3 + t), 32'(L));
    @(negedge clk); #1;
    chk({nm, "_nbits"}, 32'(bits.size()), 32'(L));
    got = '0;
    for (int i = 0; i < bits.size() && i < 32; i++) got[31-i] = bits[i];
    chk({nm, "_bits"}, got, v.exp);
    chk({nm, "_nwrites"}, 32'(wrs.size()), 32'(nw));
    for (int i = 0; i < wrs.size() && i < nw; i++)
      chk({nm, "_byte"}, 32'(wrs[i]), 32'(v.exp[31-8*i -: 8]));
  endtask

  task automatic do_pad(input int exp_n, input string nm);
    int c, fc;
    logic [7:0] orv;
    wrs.delete();
    pi_end = 1;
    @(posedge clk); #1;
    pi_end = 0;
    fc = -1; c = 0;
    while (fc < 0 && c < 2 * CAP + 8) begin
      @(negedge clk);
      if (oem_finish) fc = c;
      c++;
    end
    #1;
    chk({nm, "_pad_writes"}, 32'(wrs.size()), 32'(exp_n));
    chk({nm, "_finish_cycle"}, 32'(fc), 32'(exp_n == 0 ? 1 : 2 * exp_n));
    orv = 8'h00;
    foreach (wrs[i]) orv = orv | wrs[i];
    chk({nm, "_pad_zero"}, 32'(orv), 32'h0);
    // DONE is terminal: load ignored, finish sticky
    bits.delete();
    load = 1;
    repeat (4) @(posedge clk);
    #1 load = 0;
    chk({nm, "_done_sticky"}, 32'({oem_finish, ready}), 32'b10);
    chk({nm, "_done_no_tx"}, 32'(bits.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tv[0] = '{2'd0, 1'b0, 1'b1, 1'b1, 16'hA53C, 32'hA5000000};
    tv[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 16'h0001, 32'h80000000};
    tv[2] = '{2'd2, 1'b1, 1'b1, 1'b0, 16'hBEEF, 32'hBEEF0000};
    tv[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'hA53C, 32'h3C000000};
    tv[4] = '{2'd1, 1'b0, 1'b1, 1'b0, 16'h1234, 32'h12340000};
    tv[5] = '{2'd1, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h2C480000};
    tv[6] = '{2'd0, 1'b0, 1'b0, 1'b1, 16'h1E80, 32'h78000000};
    tv[7] = '{2'd2, 1'b0, 1'b1, 1'b0, 16'hBEEF, 32'h00BEEF00};
    tv[8] = '{2'd3, 1'b1, 1'b1, 1'b0, 16'hCAFE, 32'hCAFE0000};
    tv[9] = '{2'd2, 1'b1, 1'b0, 1'b0, 16'h8001, 32'h00800100};

    do_reset("por");
    for (int i = 0; i < 10; i++) send(tv[i], int'(tv[i].len) + 1, $sformatf("tv%0d", i));

    // reset at bit 12 of a 32-bit frame, then restart at k=0
    bits.delete();
    pi_length = 2'd3; pi_fill = 1; pi_msb = 1; pi_low = 0; pi_data = 16'hA5A5;
    load = 1;
    @(posedge clk); #1;
    load = 0;
    repeat (12) @(posedge clk);
    #1 chk("abort_pre_byte", 32'(oem_dataout), 32'hA5);
    do_reset("abort");
    send(tv[0], 1, "abort_restart");

    // 32 frames of 32 bits, then pad the upper two groups
    do_reset("fill");
    for (int i = 0; i < 32; i++) begin
      v = '{2'd3, 1'b1, 1'b1, 1'b0, 16'(i * 97 + 5), {16'(i * 97 + 5), 16'h0}};
      send(v, 4, "fill");
    end
    do_pad(128, "fill");

    // memory full: extra frame still serialised but not written
    do_reset("ovf");
    for (int i = 0; i < 64; i++) begin
      v = '{2'd3, 1'b1, 1'b1, 1'b0, 16'(i + 1), {16'(i + 1), 16'h0}};
      send(v, 4, "ovf");
    end
    send(tv[8], 0, "ovf_extra");
    do_pad(0, "ovf");

    // pad everything from k=0
    do_reset("padall");
    do_pad(CAP, "padall");

    // 16 single-byte frames, odd/even layout checked by the scoreboard
    do_reset("rows");
    for (int i = 0; i < 16; i++) begin
      v = '{2'd0, 1'b0, 1'b1, 1'b0, 16'(i * 17 + 3), {8'(i * 17 + 3), 24'h0}};
      send(v, 1, "rows");
    end
    chk("rows_k", 32'(exp_k), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
